// File: rtl/emu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : emu_run_ctrl_if
// Brief    : Command, time and run-status bundle between the host/debug side
//            and the emulator run-control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface emu_run_ctrl_if #(
    parameter int TIME_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [TIME_WIDTH-1:0] cmd_arg;
    logic                  abort;
    logic [TIME_WIDTH-1:0] emu_time;
    logic [1:0]            emu_ctrl_mode;
    logic [TIME_WIDTH-1:0] emu_time_tgt;
    logic                  busy;
    logic                  done;
    logic                  stall_err;

    // Host/debug side: issues commands and supplies the current time.
    modport master (
        output cmd_valid, cmd_op, cmd_arg, abort, emu_time,
        input  cmd_ready, emu_ctrl_mode, emu_time_tgt, busy, done, stall_err
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, abort, emu_time,
        output cmd_ready, emu_ctrl_mode, emu_time_tgt, busy, done, stall_err
    );
endinterface
`default_nettype wire

// File: rtl/emu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : emu_run_ctrl
// Brief    : Run-control sequencer. Accepts free-run / stop / run-until /
//            run-for commands, drives the time-management mode and absolute
//            time target, detects target arrival and stalled emulation time.
// Revision : 1.0 - initial release
// ============================================================================
module emu_run_ctrl #(
    parameter int TIME_WIDTH   = 32,
    parameter int STALL_CYCLES = 1024,
    parameter int STALL_W      = $clog2(STALL_CYCLES + 1)
) (
    input  logic           __emu_clk,
    input  logic           __emu_rst,
    emu_run_ctrl_if.slave  bus
);

    // Counter needs at least one bit even when the watchdog is disabled.
    localparam int c_CNT_W = (STALL_W < 1) ? 1 : STALL_W;
    localparam bit c_WD_EN = (STALL_CYCLES > 0);
    localparam logic [c_CNT_W-1:0] c_STALL_LAST =
        (STALL_CYCLES > 0) ? c_CNT_W'(STALL_CYCLES - 1) : '0;

    // State codes equal the emu_ctrl_mode encoding so mode is the state register.
    localparam logic [1:0] c_ST_FREE = 2'b00;
    localparam logic [1:0] c_ST_IDLE = 2'b01;
    localparam logic [1:0] c_ST_RUN  = 2'b10;

    localparam logic [1:0] c_OP_FREE_RUN  = 2'b00;
    localparam logic [1:0] c_OP_STOP      = 2'b01;
    localparam logic [1:0] c_OP_RUN_UNTIL = 2'b10;
    localparam logic [1:0] c_OP_RUN_FOR   = 2'b11;

    logic [1:0]            r_state;
    logic [TIME_WIDTH-1:0] r_tgt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_stall_err;
    logic [c_CNT_W-1:0]    r_stall_cnt;
    logic [TIME_WIDTH-1:0] r_time_q;

    logic                  w_accept;
    logic                  w_tgt_hit;
    logic                  w_time_moved;
    logic                  w_stalled;
    logic [TIME_WIDTH:0]   w_sum;
    logic [TIME_WIDTH-1:0] w_rel_tgt;

    assign bus.cmd_ready     = !bus.abort && (r_state != c_ST_RUN);
    assign bus.emu_ctrl_mode = r_state;
    assign bus.emu_time_tgt  = r_tgt;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.stall_err     = r_stall_err;

    assign w_accept     = bus.cmd_valid && bus.cmd_ready;
    assign w_tgt_hit    = (bus.emu_time >= r_tgt);
    assign w_time_moved = (bus.emu_time != r_time_q);
    assign w_stalled    = c_WD_EN && !w_time_moved && (r_stall_cnt == c_STALL_LAST);

    // Relative target: a carry out means the target is beyond representable time.
    assign w_sum     = {1'b0, bus.emu_time} + {1'b0, bus.cmd_arg};
    assign w_rel_tgt = w_sum[TIME_WIDTH] ? {TIME_WIDTH{1'b1}} : w_sum[TIME_WIDTH-1:0];

    // Sequencer: abort > target reached > stall > command.
    always_ff @(posedge __emu_clk or posedge __emu_rst) begin
        if (__emu_rst) begin
            r_state     <= c_ST_IDLE;
            r_tgt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stall_err <= 1'b0;
            r_stall_cnt <= '0;
            r_time_q    <= '0;
        end else begin
            r_time_q <= bus.emu_time;
            r_done   <= 1'b0;
            if (bus.abort) begin
                r_state <= c_ST_IDLE;
                r_busy  <= 1'b0;
            end else if (r_state == c_ST_RUN) begin
                if (w_tgt_hit) begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else if (w_stalled) begin
                    r_state     <= c_ST_IDLE;
                    r_busy      <= 1'b0;
                    r_stall_err <= 1'b1;
                end else if (c_WD_EN) begin
                    r_stall_cnt <= w_time_moved ? '0 : r_stall_cnt + c_CNT_W'(1);
                end
            end else if (w_accept) begin
                r_stall_err <= 1'b0;
                case (bus.cmd_op)
                    c_OP_FREE_RUN: begin
                        r_state <= c_ST_FREE;
                        r_busy  <= 1'b0;
                    end
                    c_OP_STOP: begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    c_OP_RUN_UNTIL: begin
                        r_state     <= c_ST_RUN;
                        r_busy      <= 1'b1;
                        r_tgt       <= bus.cmd_arg;
                        r_stall_cnt <= '0;
                    end
                    c_OP_RUN_FOR: begin
                        r_state     <= c_ST_RUN;
                        r_busy      <= 1'b1;
                        r_tgt       <= w_rel_tgt;
                        r_stall_cnt <= '0;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_emu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_emu_run_ctrl
// Brief    : Self-checking bench for emu_run_ctrl with a timestamp-based
//            reference model and a queue-driven output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emu_run_ctrl;

    localparam int c_TW    = 32;
    localparam int c_STALL = 8;

    localparam int c_M_FREE = 0;
    localparam int c_M_IDLE = 1;
    localparam int c_M_RUN  = 2;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] tgt;
        logic        busy;
        logic        done;
        logic        err;
        logic        ready;
    } exp_t;

    logic clk;
    logic rst;

    emu_run_ctrl_if #(.TIME_WIDTH(c_TW)) bus ();

    emu_run_ctrl #(
        .TIME_WIDTH   (c_TW),
        .STALL_CYCLES (c_STALL)
    ) dut (
        .__emu_clk (clk),
        .__emu_rst (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q[$];

    // Reference model state: run state, target, error flag, and the cycle
    // index from which "time has been frozen" is measured.
    int          m_st;
    logic [31:0] m_tgt;
    logic        m_err;
    logic [31:0] m_prev_t;
    longint      m_cyc;
    longint      m_ref;
    logic [31:0] cur_t;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_st     = c_M_IDLE;
        m_tgt    = '0;
        m_err    = 1'b0;
        m_prev_t = '0;
        m_cyc    = 0;
        m_ref    = 0;
    endfunction

    // One clock edge of behaviour, evaluated from the rules directly.
    function automatic exp_t model_edge(logic v, logic [1:0] op, logic [31:0] arg,
                                        logic ab, logic [31:0] t);
        exp_t   e;
        logic   done;
        longint s;
        done = 1'b0;
        if (m_st == c_M_RUN && t != m_prev_t) m_ref = m_cyc;
        if (ab) begin
            m_st = c_M_IDLE;
        end else if (m_st == c_M_RUN) begin
            if (t >= m_tgt) begin
                m_st = c_M_IDLE;
                done = 1'b1;
            end else if (m_cyc - m_ref >= c_STALL) begin
                m_st  = c_M_IDLE;
                m_err = 1'b1;
            end
        end else if (v) begin
            m_err = 1'b0;
            case (op)
                2'd0: m_st = c_M_FREE;
                2'd1: m_st = c_M_IDLE;
                2'd2: begin m_tgt = arg; m_st = c_M_RUN; m_ref = m_cyc; end
                default: begin
                    s = longint'(t) + longint'(arg);
                    m_tgt = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
                    m_st  = c_M_RUN;
                    m_ref = m_cyc;
                end
            endcase
        end
        m_prev_t = t;
        m_cyc++;
        e.mode  = (m_st == c_M_FREE) ? 2'b00 : (m_st == c_M_IDLE) ? 2'b01 : 2'b10;
        e.tgt   = m_tgt;
        e.busy  = (m_st == c_M_RUN);
        e.done  = done;
        e.err   = m_err;
        e.ready = !ab && (m_st != c_M_RUN);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] arg,
                         input logic ab, input logic [31:0] t);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.abort     = ab;
        bus.emu_time  = t;
        cur_t         = t;
        q.push_back(model_edge(v, op, arg, ab, t));
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] arg,
                        input logic ab, input logic [31:0] t);
        @(negedge clk);
        drive(v, op, arg, ab, t);
    endtask

    task automatic idle(input int n, input logic [31:0] t);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0, 1'b0, t);
    endtask

    // Monitor: each clock the DUT presents a new output set; compare it
    // with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mode",      32'(bus.emu_ctrl_mode), 32'(e.mode));
                chk("tgt",       bus.emu_time_tgt,       e.tgt);
                chk("busy",      32'(bus.busy),          32'(e.busy));
                chk("done",      32'(bus.done),          32'(e.done));
                chk("stall_err", 32'(bus.stall_err),     32'(e.err));
                chk("cmd_ready", 32'(bus.cmd_ready),     32'(e.ready));
            end
        end
    end

    initial begin
        logic [31:0] t;
        logic        frz;
        logic [1:0]  op;
        logic [31:0] arg;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_arg   = '0;
        bus.abort     = 1'b0;
        bus.emu_time  = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset values, sampled before any post-reset edge.
        rst = 1'b0;
        #1;
        chk("rst_mode",      32'(bus.emu_ctrl_mode), 32'h1);
        chk("rst_tgt",       bus.emu_time_tgt,       32'h0);
        chk("rst_busy",      32'(bus.busy),          32'h0);
        chk("rst_done",      32'(bus.done),          32'h0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready),     32'h1);
        chk("rst_stall_err", 32'(bus.stall_err),     32'h0);

        // RUN_FOR 100 at time 500, then ramp +10 per clock.
        step(1'b1, 2'd3, 32'd100, 1'b0, 32'd500);
        for (int i = 1; i <= 14; i++) step(1'b0, 2'd0, 32'd0, 1'b0, 32'd500 + 32'(10 * i));

        // RUN_UNTIL a target already in the past.
        step(1'b1, 2'd2, 32'd50, 1'b0, 32'd80);
        idle(3, 32'd80);

        // Frozen time: watchdog trips, then FREE_RUN clears the flag.
        step(1'b1, 2'd2, 32'd1000, 1'b0, 32'd10);
        idle(11, 32'd10);
        step(1'b1, 2'd0, 32'd0, 1'b0, 32'd10);
        idle(2, 32'd10);

        // Abort on the very cycle the target is reached; abort blocks a command.
        step(1'b1, 2'd1, 32'd0, 1'b0, 32'd100);
        step(1'b1, 2'd2, 32'd200, 1'b0, 32'd100);
        step(1'b0, 2'd0, 32'd0, 1'b0, 32'd150);
        step(1'b0, 2'd0, 32'd0, 1'b1, 32'd200);
        step(1'b1, 2'd0, 32'd0, 1'b1, 32'd200);
        idle(2, 32'd200);

        // Saturating RUN_FOR, then asynchronous reset while running.
        step(1'b1, 2'd3, 32'h20, 1'b0, 32'hFFFF_FFF0);
        idle(2, 32'hFFFF_FFF0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mode", 32'(bus.emu_ctrl_mode), 32'h1);
        chk("arst_tgt",  bus.emu_time_tgt,       32'h0);
        chk("arst_busy", 32'(bus.busy),          32'h0);
        chk("arst_done", 32'(bus.done),          32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 1'b0, 32'd0);

        // Randomised traffic: time walks forward with frozen stretches.
        t   = 32'd0;
        frz = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) frz = ~frz;
            if (!frz) t = t + 32'($urandom_range(0, 12));
            op  = 2'($urandom_range(0, 3));
            arg = (op == 2'd2) ? t + 32'($urandom_range(0, 120)) - 32'd10
                               : 32'($urandom_range(0, 120));
            step(1'($urandom_range(0, 1)), op, arg, ($urandom_range(0, 24) == 0), t);
        end
        idle(2, t);

        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
